// File: rtl/mem_arbiter.sv
// Shares the single-port program/data memory between the CPU path and the
// external loader port using a 3-state access sequencer with round-robin arbitration.
module mem_arbiter #(
  parameter int unsigned WIDTH_REG         = 8,
  parameter int unsigned WIDTH_ADDRESS_BIT = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // CPU requester
  input  logic                         cpu_req_i,
  input  logic                         cpu_wr_i,
  input  logic [WIDTH_ADDRESS_BIT-1:0] cpu_addr_i,
  input  logic [WIDTH_REG-1:0]         cpu_wdata_i,
  output logic                         cpu_gnt_o,
  output logic                         cpu_rvalid_o,
  output logic [WIDTH_REG-1:0]         cpu_rdata_o,
  output logic                         cpu_stall_o,
  // External loader/debug requester
  input  logic                         ext_req_i,
  input  logic                         ext_wr_i,
  input  logic [WIDTH_ADDRESS_BIT-1:0] ext_addr_i,
  input  logic [WIDTH_REG-1:0]         ext_wdata_i,
  output logic                         ext_gnt_o,
  output logic                         ext_rvalid_o,
  output logic [WIDTH_REG-1:0]         ext_rdata_o,
  // Memory side
  output logic                         mem_rd_o,
  output logic                         mem_wr_o,
  output logic [WIDTH_ADDRESS_BIT-1:0] mem_addr_o,
  output logic [WIDTH_REG-1:0]         mem_wdata_o,
  input  logic [WIDTH_REG-1:0]         mem_rdata_i,
  // Status
  output logic                         owner_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                       state_q, state_d;
  logic                         wr_q, wr_d;
  logic [WIDTH_ADDRESS_BIT-1:0] addr_q, addr_d;
  logic [WIDTH_REG-1:0]         wdata_q, wdata_d;
  logic                         owner_q, owner_d;
  logic                         last_owner_q, last_owner_d;
  logic [WIDTH_REG-1:0]         cpu_rdata_q, cpu_rdata_d;
  logic [WIDTH_REG-1:0]         ext_rdata_q, ext_rdata_d;
  logic                         cpu_rvalid_q, cpu_rvalid_d;
  logic                         ext_rvalid_q, ext_rvalid_d;

  logic any_req;
  logic winner;
  logic issue;

  assign any_req = cpu_req_i | ext_req_i;
  // On a tie the requester that did not own the last access wins.
  assign winner  = (cpu_req_i & ext_req_i) ? ~last_owner_q : ext_req_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if (state_q == StIdle && any_req) begin
      wr_d         = winner ? ext_wr_i    : cpu_wr_i;
      addr_d       = winner ? ext_addr_i  : cpu_addr_i;
      wdata_d      = winner ? ext_wdata_i : cpu_wdata_i;
      owner_d      = winner;
      last_owner_d = winner;
    end
  end

  // Read data is captured at the end of RESP; rvalid pulses in the following cycle.
  always_comb begin
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    cpu_rvalid_d = 1'b0;
    ext_rvalid_d = 1'b0;
    if (state_q == StResp && !wr_q) begin
      if (owner_q) begin
        ext_rdata_d  = mem_rdata_i;
        ext_rvalid_d = 1'b1;
      end else begin
        cpu_rdata_d  = mem_rdata_i;
        cpu_rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  // Strobes and grants decode straight from state so an async reset drops them at once.
  assign issue        = (state_q == StIssue);
  assign cpu_gnt_o    = issue & ~owner_q;
  assign ext_gnt_o    = issue & owner_q;
  assign mem_rd_o     = issue & ~wr_q;
  assign mem_wr_o     = issue & wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign ext_rvalid_o = ext_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign ext_rdata_o  = ext_rdata_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q != StIdle);
  assign cpu_stall_o  = cpu_req_i & ~(busy_o & ~owner_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, transaction-timing reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_wr, ext_req, ext_wr;
  logic [4:0] cpu_addr, ext_addr, mem_addr;
  logic [7:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata, cpu_rdata, ext_rdata;
  logic       cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid;
  logic       mem_rd, mem_wr, owner, busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  mem_arbiter #(.WIDTH_REG(8), .WIDTH_ADDRESS_BIT(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .ext_req_i(ext_req), .ext_wr_i(ext_wr), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .owner_o(owner), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory instance: registered read, data valid the cycle after mem_rd.
  logic [7:0] env_mem [32];
  bit         env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= 8'(i * 29 + 7);
      env_init <= 1'b1;
    end else begin
      if (mem_wr) env_mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= env_mem[mem_addr];
    end
  end

  // Grant seen in the previous cycle, for the random requesters.
  logic cg_s = 1'b0, eg_s = 1'b0;
  always @(negedge clk) begin
    cg_s <= cpu_gnt;
    eg_s <= ext_gnt;
  end

  // Reference model: an access decided in cycle t grants at t+1, returns data at t+3,
  // and the next decision can happen at t+3.
  int         acc_t = -1;
  logic       acc_who, acc_wr;
  logic [4:0] acc_addr;
  logic [7:0] acc_wdata, pend_rd;
  int         rv_t [2];
  logic       own_m, last_m;
  logic [4:0] haddr_m;
  logic [7:0] hwd_m;
  logic [7:0] rd_m [2];
  logic [7:0] mem_m [32];
  bit         mem_m_init = 1'b0;

  always @(negedge clk) begin
    int   d;
    logic e_iss, e_busy, win;
    if (!mem_m_init) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 8'(i * 29 + 7);
      mem_m_init = 1'b1;
    end
    if (!rst_n) begin
      acc_t = -1; own_m = 1'b0; last_m = 1'b1; haddr_m = '0; hwd_m = '0;
      rd_m[0] = '0; rd_m[1] = '0; rv_t[0] = -10; rv_t[1] = -10;
    end
    d      = (acc_t >= 0) ? cyc - acc_t : 99;
    e_iss  = (d == 1);
    e_busy = (d == 1) || (d == 2);
    chk("cpu_gnt",    cpu_gnt,    e_iss & ~acc_who);
    chk("ext_gnt",    ext_gnt,    e_iss & acc_who);
    chk("mem_rd",     mem_rd,     e_iss & ~acc_wr);
    chk("mem_wr",     mem_wr,     e_iss & acc_wr);
    chk("mem_addr",   mem_addr,   haddr_m);
    chk("mem_wdata",  mem_wdata,  hwd_m);
    chk("cpu_rvalid", cpu_rvalid, rv_t[0] == cyc);
    chk("ext_rvalid", ext_rvalid, rv_t[1] == cyc);
    chk("cpu_rdata",  cpu_rdata,  rd_m[0]);
    chk("ext_rdata",  ext_rdata,  rd_m[1]);
    chk("owner",      owner,      own_m);
    chk("busy",       busy,       e_busy);
    chk("cpu_stall",  cpu_stall,  cpu_req & ~(e_busy & ~own_m));
    if (rst_n) begin
      if (d == 1) begin
        if (acc_wr) mem_m[acc_addr] = acc_wdata;
        else        pend_rd = mem_m[acc_addr];
      end
      if (d == 2 && !acc_wr) begin
        rd_m[acc_who] = pend_rd;
        rv_t[acc_who] = cyc + 1;
      end
      if (d >= 3 && (cpu_req || ext_req)) begin
        win       = (cpu_req && ext_req) ? ~last_m : ext_req;
        acc_t     = cyc;
        acc_who   = win;
        acc_wr    = win ? ext_wr    : cpu_wr;
        acc_addr  = win ? ext_addr  : cpu_addr;
        acc_wdata = win ? ext_wdata : cpu_wdata;
        own_m     = win;
        last_m    = win;
        haddr_m   = acc_addr;
        hwd_m     = acc_wdata;
      end
    end
  end

  // Drive point: just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input bit who, input bit r, input bit wr, input logic [4:0] a,
                         input logic [7:0] wd);
    if (who) begin ext_req = r; ext_wr = wr; ext_addr = a; ext_wdata = wd; end
    else     begin cpu_req = r; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; end
  endtask

  // Full access with a bounded wait for the grant; returns at the drive point after gnt.
  task automatic access(input bit who, input bit wr, input logic [4:0] a,
                        input logic [7:0] wd);
    bit got = 1'b0;
    set_req(who, 1'b1, wr, a, wd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who ? ext_gnt : cpu_gnt) begin got = 1'b1; break; end
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
    step();
    set_req(who, 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic read_lit(input bit who, input logic [4:0] a, input logic [7:0] exp);
    idle(3);
    set_req(who, 1'b1, 1'b0, a, 8'd0);
    negs(2);
    chk("lit_gnt", who ? ext_gnt : cpu_gnt, 1'b1);
    chk("lit_mem_rd", mem_rd, 1'b1);
    chk("lit_mem_addr", mem_addr, a);
    step();
    set_req(who, 1'b0, 1'b0, 5'd0, 8'd0);
    negs(2);
    chk("lit_rvalid", who ? ext_rvalid : cpu_rvalid, 1'b1);
    chk("lit_rdata", who ? ext_rdata : cpu_rdata, exp);
    step();
  endtask

  task automatic rand_req(input bit who, input bit gseen);
    logic r;
    r = who ? ext_req : cpu_req;
    if (r && gseen) begin
      if ($urandom_range(0, 1) == 0) set_req(who, 1'b0, 1'b0, 5'd0, 8'd0);
      else set_req(who, 1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
    end else if (!r && $urandom_range(0, 2) == 0) begin
      set_req(who, 1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    idle(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_mem_addr", mem_addr, 5'd0);
    chk("rst_cpu_rdata", cpu_rdata, 8'd0);
    rst_n = 1'b1;

    // Preload through the loader port, then a single CPU read.
    access(1'b1, 1'b1, 5'd3, 8'hA7);
    access(1'b1, 1'b1, 5'd5, 8'h33);
    read_lit(1'b0, 5'd3, 8'hA7);

    // External write (no rvalid) then CPU reads it back.
    access(1'b1, 1'b1, 5'd31, 8'h5C);
    negs(2);
    chk("ext_wr_no_rvalid", ext_rvalid, 1'b0);
    step();
    read_lit(1'b0, 5'd31, 8'h5C);

    // Reset during the ISSUE of a CPU write to address 5.
    idle(3);
    set_req(1'b0, 1'b1, 1'b1, 5'd5, 8'hEE);
    step();
    chk("issue_mem_wr", mem_wr, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_wr", mem_wr, 1'b0);
    chk("arst_gnt", cpu_gnt, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_mem_wdata", mem_wdata, 8'd0);
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    idle(2);
    rst_n = 1'b1;
    read_lit(1'b1, 5'd5, 8'h33);

    // Contention from reset release: CPU, EXT, CPU, EXT, 3 cycles apart.
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 5'd7, 8'd0);
    set_req(1'b1, 1'b1, 1'b0, 5'd9, 8'd0);
    idle(2);
    rst_n = 1'b1;
    negs(2);
    chk("cont_g0_cpu", {cpu_gnt, ext_gnt}, 2'b10);
    negs(3);
    chk("cont_g1_ext", {cpu_gnt, ext_gnt}, 2'b01);
    chk("cont_stall", cpu_stall, 1'b1);
    negs(3);
    chk("cont_g2_cpu", {cpu_gnt, ext_gnt}, 2'b10);
    negs(3);
    chk("cont_g3_ext", {cpu_gnt, ext_gnt}, 2'b01);
    step();
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);

    // Late external request during the ISSUE of a CPU access.
    idle(3);
    set_req(1'b0, 1'b1, 1'b0, 5'd2, 8'd0);
    step();
    set_req(1'b1, 1'b1, 1'b0, 5'd4, 8'd0);
    @(negedge clk);
    chk("late_cpu_gnt", {cpu_gnt, ext_gnt}, 2'b10);
    step();
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    negs(2);
    chk("late_no_early_gnt", ext_gnt, 1'b0);
    negs(1);
    chk("late_ext_gnt", ext_gnt, 1'b1);
    chk("late_mem_addr", mem_addr, 5'd4);
    step();
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);

    // Back-to-back CPU reads of 0,1,2 with req held, after a fresh reset.
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
    negs(2);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] expv [3];
      expv[0] = 8'h07; expv[1] = 8'h24; expv[2] = 8'h41;
      chk("b2b_gnt", cpu_gnt, 1'b1);
      chk("b2b_addr", mem_addr, 5'(i));
      step();
      if (i < 2) set_req(1'b0, 1'b1, 1'b0, 5'(i + 1), 8'd0);
      else       set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
      negs(2);
      chk("b2b_rvalid", cpu_rvalid, 1'b1);
      chk("b2b_rdata", cpu_rdata, expv[i]);
      if (i < 2) negs(1);
    end
    chk("b2b_ext_rdata", ext_rdata, 8'd0);
    step();

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 199) != 0);
      rand_req(1'b0, cg_s);
      rand_req(1'b1, eg_s);
    end
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
